datamover_cmd_splitter: RTL and testbench

DATAMOVER_CMD_SPLITTER -- requirements
Module: datamover_cmd_splitter

---
 rtl/datamover_cmd_splitter.sv | 196 +++++++++++++++++++
 tb/tb_datamover_cmd_splitter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/datamover_cmd_splitter.sv
// -----------------------------------------------------------------------------
// datamover_cmd_splitter
//
// Accepts one upstream DataMover-format command and splits it into chunks.
// No chunk crosses a MAX_BTT-aligned address boundary. Chunks are issued to
// the DataMover, with at most MAX_OUTSTANDING commands waiting for status at
// any time. Once all chunks are issued and all their statuses have returned,
// a single aggregated status byte is reported for the upstream command.
//
// Ports
//   S_AXI_ACLK         clock (rising edge)
//   S_AXI_ARESET       asynchronous active-high reset
//   pi_usr_rst         synchronous soft reset, same effect as S_AXI_ARESET
//   pi_cmd/_valid      upstream command; po_cmd_ready accepts it (IDLE only)
//   po_sts_tdata/valid aggregated status, one-cycle pulse, no back-pressure
//   po_dm_cmd_*        chunk command to the DataMover (valid/ready)
//   pi_dm_sts_*        per-chunk status from the DataMover (valid/ready)
//   po_busy            high while a command is in progress
//
// Command layout: [22:0] BTT, [23] TYPE, [29:24] DSA, [30] EOF, [31] DRR,
//                 [63:32] SADDR, [67:64] TAG, [71:68] RSVD
// Status layout:  [3:0] TAG, [4] INTERR, [5] DECERR, [6] SLVERR, [7] OKAY
// -----------------------------------------------------------------------------
module datamover_cmd_splitter #(
  parameter int MAX_BTT         = 4096,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESET,
  input  logic        pi_usr_rst,
  input  logic [71:0] pi_cmd,
  input  logic        pi_cmd_valid,
  output logic        po_cmd_ready,
  output logic [7:0]  po_sts_tdata,
  output logic        po_sts_tvalid,
  output logic [71:0] po_dm_cmd_tdata,
  output logic        po_dm_cmd_tvalid,
  input  logic        pi_dm_cmd_tready,
  input  logic [7:0]  pi_dm_sts_tdata,
  input  logic        pi_dm_sts_tvalid,
  output logic        po_dm_sts_tready,
  output logic        po_busy
);

  localparam int LOG2_BTT = $clog2(MAX_BTT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_STS, REPORT} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  outstanding;
  logic [22:0] remaining;
  logic        acc_int;
  logic        acc_dec;
  logic        acc_slv;
  logic        acc_ok;

  // Captured command fields; these are pure datapath and carry no reset.
  logic [31:0] addr;
  logic [3:0]  tag;
  logic        cmd_type;
  logic [5:0]  dsa;
  logic        drr;
  logic        eof;

  logic        rst_any;
  logic        accept;
  logic        cmd_hs;
  logic        sts_hs;
  logic        can_issue;
  logic [22:0] len;
  logic        last_chunk;
  logic        unused_bits;

  // Bytes left until the next MAX_BTT-aligned boundary, clipped to remaining.
  function automatic logic [22:0] chunk_len(input logic [31:0] a,
                                            input logic [22:0] rem);
    logic [22:0] room;
    room = 23'(MAX_BTT) - 23'(a[LOG2_BTT-1:0]);
    return (rem < room) ? rem : room;
  endfunction

  assign rst_any     = S_AXI_ARESET | pi_usr_rst;
  assign len         = chunk_len(addr, remaining);
  assign last_chunk  = (len == remaining);
  assign can_issue   = (state == ISSUE) && (outstanding < 4'(MAX_OUTSTANDING));
  assign unused_bits = ^{pi_cmd[71:68], pi_dm_sts_tdata[3:0]};

  // Every output is forced low while either reset is asserted, including the
  // soft reset, which only takes effect on the state at the next edge.
  assign po_cmd_ready     = (state == IDLE) && !rst_any;
  assign po_dm_cmd_tvalid = can_issue && !rst_any;
  assign po_dm_sts_tready = ((state == ISSUE) || (state == WAIT_STS)) && !rst_any;
  assign po_sts_tvalid    = (state == REPORT) && !rst_any;
  assign po_busy          = (state != IDLE) && !rst_any;

  assign po_dm_cmd_tdata  = po_dm_cmd_tvalid
                            ? {4'b0000, tag, addr, drr, eof & last_chunk, dsa, cmd_type, len}
                            : 72'd0;
  assign po_sts_tdata     = po_sts_tvalid
                            ? {acc_ok & ~(acc_int | acc_dec | acc_slv), acc_slv, acc_dec, acc_int, tag}
                            : 8'd0;

  assign accept = po_cmd_ready & pi_cmd_valid;
  assign cmd_hs = po_dm_cmd_tvalid & pi_dm_cmd_tready;
  assign sts_hs = pi_dm_sts_tvalid & po_dm_sts_tready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (pi_cmd[22:0] != 23'd0) ? ISSUE : REPORT;
        end
      end
      ISSUE: begin
        if (cmd_hs && last_chunk) begin
          state_nxt = WAIT_STS;
        end
      end
      WAIT_STS: begin
        // Look at the count after this cycle's status so the report follows
        // the final status by exactly one cycle.
        if ((outstanding == 4'd0) || ((outstanding == 4'd1) && sts_hs)) begin
          state_nxt = REPORT;
        end
      end
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control state: FSM, outstanding count, remaining bytes and the status
  // accumulators.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      state       <= IDLE;
      outstanding <= 4'd0;
      remaining   <= 23'd0;
      acc_int     <= 1'b0;
      acc_dec     <= 1'b0;
      acc_slv     <= 1'b0;
      acc_ok      <= 1'b0;
    end else if (pi_usr_rst) begin
      state       <= IDLE;
      outstanding <= 4'd0;
      remaining   <= 23'd0;
      acc_int     <= 1'b0;
      acc_dec     <= 1'b0;
      acc_slv     <= 1'b0;
      acc_ok      <= 1'b0;
    end else begin
      state <= state_nxt;

      case ({cmd_hs, sts_hs})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   outstanding <= outstanding - 4'd1;
        default: outstanding <= outstanding;
      endcase

      if (accept) begin
        remaining <= pi_cmd[22:0];
        // A zero-length request reports an internal error without issuing.
        acc_int   <= (pi_cmd[22:0] == 23'd0);
        acc_dec   <= 1'b0;
        acc_slv   <= 1'b0;
        acc_ok    <= (pi_cmd[22:0] != 23'd0);
      end else begin
        if (cmd_hs) begin
          remaining <= remaining - len;
        end
        if (sts_hs) begin
          acc_int <= acc_int | pi_dm_sts_tdata[4];
          acc_dec <= acc_dec | pi_dm_sts_tdata[5];
          acc_slv <= acc_slv | pi_dm_sts_tdata[6];
          acc_ok  <= acc_ok  & pi_dm_sts_tdata[7];
        end
      end
    end
  end

  // Datapath: captured fields and the running chunk address.
  always_ff @(posedge S_AXI_ACLK) begin
    if (accept) begin
      addr     <= pi_cmd[63:32];
      tag      <= pi_cmd[67:64];
      cmd_type <= pi_cmd[23];
      dsa      <= pi_cmd[29:24];
      drr      <= pi_cmd[31];
      eof      <= pi_cmd[30];
    end else if (cmd_hs) begin
      addr <= addr + 32'(len);
    end
  end

endmodule

// File: tb/tb_datamover_cmd_splitter.sv
module tb_datamover_cmd_splitter;

  logic        clk;
  logic        rst;
  logic        usr_rst;
  logic [71:0] cmd;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  sts_tdata;
  logic        sts_tvalid;
  logic [71:0] dm_cmd_tdata;
  logic        dm_cmd_tvalid;
  logic        dm_cmd_tready;
  logic [7:0]  dm_sts_tdata;
  logic        dm_sts_tvalid;
  logic        dm_sts_tready;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  datamover_cmd_splitter #(.MAX_BTT(4096), .MAX_OUTSTANDING(4)) dut (
    .S_AXI_ACLK       (clk),
    .S_AXI_ARESET     (rst),
    .pi_usr_rst       (usr_rst),
    .pi_cmd           (cmd),
    .pi_cmd_valid     (cmd_valid),
    .po_cmd_ready     (cmd_ready),
    .po_sts_tdata     (sts_tdata),
    .po_sts_tvalid    (sts_tvalid),
    .po_dm_cmd_tdata  (dm_cmd_tdata),
    .po_dm_cmd_tvalid (dm_cmd_tvalid),
    .pi_dm_cmd_tready (dm_cmd_tready),
    .pi_dm_sts_tdata  (dm_sts_tdata),
    .pi_dm_sts_tvalid (dm_sts_tvalid),
    .po_dm_sts_tready (dm_sts_tready),
    .po_busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [71:0] mk_cmd(input logic [31:0] sa, input logic [22:0] btt,
                                         input logic [3:0] tg, input logic eof,
                                         input logic typ, input logic [5:0] dsa,
                                         input logic drr, input logic [3:0] rsvd);
    return {rsvd, tg, sa, drr, eof, dsa, typ, btt};
  endfunction

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic accept(input logic [71:0] c);
    chk("cmd_ready_before_accept", 72'(cmd_ready), 72'(1));
    cmd       = c;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic send_sts(input logic [7:0] d);
    chk("dm_sts_tready", 72'(dm_sts_tready), 72'(1));
    dm_sts_tdata  = d;
    dm_sts_tvalid = 1'b1;
    step();
    dm_sts_tvalid = 1'b0;
  endtask

  task automatic chk_dm(input string tag, input logic [71:0] exp);
    chk({tag, "_tvalid"}, 72'(dm_cmd_tvalid), 72'(1));
    chk(tag, dm_cmd_tdata, exp);
  endtask

  task automatic chk_rep(input string tag, input logic [7:0] exp);
    chk({tag, "_tvalid"}, 72'(sts_tvalid), 72'(1));
    chk(tag, 72'(sts_tdata), 72'(exp));
  endtask

  initial begin
    rst           = 1'b1;
    usr_rst       = 1'b0;
    cmd           = 72'd0;
    cmd_valid     = 1'b0;
    dm_cmd_tready = 1'b0;
    dm_sts_tdata  = 8'd0;
    dm_sts_tvalid = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_cmd_ready", 72'(cmd_ready), 72'(0));
    chk("rst_busy", 72'(busy), 72'(0));
    chk("rst_dm_tvalid", 72'(dm_cmd_tvalid), 72'(0));
    chk("rst_sts_tvalid", 72'(sts_tvalid), 72'(0));
    chk("rst_dm_sts_tready", 72'(dm_sts_tready), 72'(0));
    rst = 1'b0;
    step();
    chk("rel_cmd_ready", 72'(cmd_ready), 72'(1));
    chk("rel_busy", 72'(busy), 72'(0));

    // Two aligned 4 KiB chunks, EOF only on the last
    dm_cmd_tready = 1'b1;
    accept(mk_cmd(32'h1000_0000, 23'h2000, 4'd3, 1'b1, 1'b0, 6'd0, 1'b0, 4'd0));
    chk("t1_busy", 72'(busy), 72'(1));
    chk("t1_ready_low", 72'(cmd_ready), 72'(0));
    chk_dm("t1_c0", mk_cmd(32'h1000_0000, 23'h1000, 4'd3, 1'b0, 1'b0, 6'd0, 1'b0, 4'd0));
    step();
    chk_dm("t1_c1", mk_cmd(32'h1000_1000, 23'h1000, 4'd3, 1'b1, 1'b0, 6'd0, 1'b0, 4'd0));
    step();
    chk("t1_wait_tvalid", 72'(dm_cmd_tvalid), 72'(0));
    send_sts(8'h83);
    chk("t1_no_early_rep", 72'(sts_tvalid), 72'(0));
    send_sts(8'h83);
    chk_rep("t1_rep", 8'h83);
    chk("t1_rep_sts_tready", 72'(dm_sts_tready), 72'(0));
    step();
    chk("t1_idle_ready", 72'(cmd_ready), 72'(1));
    chk("t1_idle_sts_tvalid", 72'(sts_tvalid), 72'(0));
    chk("t1_idle_busy", 72'(busy), 72'(0));

    // Unaligned start, field copy, RSVD cleared, back-pressure, and a
    // command handshake coinciding with a status handshake
    dm_cmd_tready = 1'b0;
    accept(mk_cmd(32'h0000_0F00, 23'h300, 4'd2, 1'b1, 1'b1, 6'h2A, 1'b1, 4'hF));
    chk_dm("t2_c0", mk_cmd(32'h0000_0F00, 23'h100, 4'd2, 1'b0, 1'b1, 6'h2A, 1'b1, 4'd0));
    step();
    chk_dm("t2_c0_hold", mk_cmd(32'h0000_0F00, 23'h100, 4'd2, 1'b0, 1'b1, 6'h2A, 1'b1, 4'd0));
    dm_cmd_tready = 1'b1;
    step();
    chk_dm("t2_c1", mk_cmd(32'h0000_1000, 23'h200, 4'd2, 1'b1, 1'b1, 6'h2A, 1'b1, 4'd0));
    send_sts(8'h82);
    chk("t2_sim_tvalid", 72'(dm_cmd_tvalid), 72'(0));
    chk("t2_sim_no_rep", 72'(sts_tvalid), 72'(0));
    step();
    chk("t2_wait_no_rep", 72'(sts_tvalid), 72'(0));
    chk("t2_wait_busy", 72'(busy), 72'(1));
    send_sts(8'h82);
    chk_rep("t2_rep", 8'h82);
    step();

    // Error aggregation: one SLVERR among OKAY statuses
    accept(mk_cmd(32'h0000_2000, 23'h3000, 4'd5, 1'b0, 1'b0, 6'd0, 1'b0, 4'd0));
    chk_dm("t3_c0", mk_cmd(32'h0000_2000, 23'h1000, 4'd5, 1'b0, 1'b0, 6'd0, 1'b0, 4'd0));
    step();
    chk_dm("t3_c1", mk_cmd(32'h0000_3000, 23'h1000, 4'd5, 1'b0, 1'b0, 6'd0, 1'b0, 4'd0));
    step();
    chk_dm("t3_c2", mk_cmd(32'h0000_4000, 23'h1000, 4'd5, 1'b0, 1'b0, 6'd0, 1'b0, 4'd0));
    step();
    chk("t3_wait_tvalid", 72'(dm_cmd_tvalid), 72'(0));
    send_sts(8'h85);
    chk("t3_no_rep0", 72'(sts_tvalid), 72'(0));
    send_sts(8'h45);
    chk("t3_no_rep1", 72'(sts_tvalid), 72'(0));
    send_sts(8'h85);
    chk_rep("t3_rep", 8'h45);
    step();

    // Outstanding limit: 6 chunks, only 4 without status
    accept(mk_cmd(32'h0000_0000, 23'h6000, 4'd1, 1'b1, 1'b0, 6'd0, 1'b0, 4'd0));
    for (int i = 0; i < 4; i++) begin
      chk_dm($sformatf("t4_c%0d", i),
             mk_cmd(32'(i) * 32'h1000, 23'h1000, 4'd1, 1'b0, 1'b0, 6'd0, 1'b0, 4'd0));
      step();
    end
    chk("t4_stall_tvalid0", 72'(dm_cmd_tvalid), 72'(0));
    chk("t4_stall_busy", 72'(busy), 72'(1));
    step();
    chk("t4_stall_tvalid1", 72'(dm_cmd_tvalid), 72'(0));
    dm_cmd_tready = 1'b0;
    send_sts(8'h81);
    chk_dm("t4_c4", mk_cmd(32'h0000_4000, 23'h1000, 4'd1, 1'b0, 1'b0, 6'd0, 1'b0, 4'd0));
    for (int k = 0; k < 5; k++) begin
      step();
      chk_dm($sformatf("t4_c4_hold%0d", k),
             mk_cmd(32'h0000_4000, 23'h1000, 4'd1, 1'b0, 1'b0, 6'd0, 1'b0, 4'd0));
    end
    dm_cmd_tready = 1'b1;
    step();
    chk("t4_stall_tvalid2", 72'(dm_cmd_tvalid), 72'(0));
    send_sts(8'h81);
    chk_dm("t4_c5", mk_cmd(32'h0000_5000, 23'h1000, 4'd1, 1'b1, 1'b0, 6'd0, 1'b0, 4'd0));
    step();
    chk("t4_wait_tvalid", 72'(dm_cmd_tvalid), 72'(0));
    for (int k = 0; k < 3; k++) begin
      send_sts(8'h81);
      chk($sformatf("t4_no_rep%0d", k), 72'(sts_tvalid), 72'(0));
    end
    send_sts(8'h81);
    chk_rep("t4_rep", 8'h81);
    step();

    // Zero-length request
    accept(mk_cmd(32'hDEAD_0000, 23'h0, 4'd7, 1'b1, 1'b0, 6'd0, 1'b0, 4'd0));
    chk_rep("t5_rep", 8'h17);
    chk("t5_no_dm_cmd", 72'(dm_cmd_tvalid), 72'(0));
    chk("t5_sts_tready", 72'(dm_sts_tready), 72'(0));
    step();
    chk("t5_idle_ready", 72'(cmd_ready), 72'(1));
    chk("t5_idle_sts_tvalid", 72'(sts_tvalid), 72'(0));

    // Asynchronous reset mid-issue, then a normal transfer
    dm_cmd_tready = 1'b0;
    accept(mk_cmd(32'h0000_0100, 23'h2000, 4'd4, 1'b1, 1'b0, 6'd0, 1'b0, 4'd0));
    chk("t6_tvalid_pre", 72'(dm_cmd_tvalid), 72'(1));
    rst = 1'b1;
    #1;
    chk("t6_rst_tvalid", 72'(dm_cmd_tvalid), 72'(0));
    chk("t6_rst_busy", 72'(busy), 72'(0));
    chk("t6_rst_ready", 72'(cmd_ready), 72'(0));
    chk("t6_rst_tdata", dm_cmd_tdata, 72'd0);
    step();
    rst = 1'b0;
    step();
    chk("t6_rel_ready", 72'(cmd_ready), 72'(1));
    chk("t6_rel_busy", 72'(busy), 72'(0));
    chk("t6_rel_sts_tvalid", 72'(sts_tvalid), 72'(0));
    dm_cmd_tready = 1'b1;
    accept(mk_cmd(32'h8000_0000, 23'h100, 4'd6, 1'b1, 1'b0, 6'd0, 1'b0, 4'd0));
    chk_dm("t6_c0", mk_cmd(32'h8000_0000, 23'h100, 4'd6, 1'b1, 1'b0, 6'd0, 1'b0, 4'd0));
    step();
    chk("t6_wait_tvalid", 72'(dm_cmd_tvalid), 72'(0));
    send_sts(8'h86);
    chk_rep("t6_rep", 8'h86);
    step();

    // Synchronous soft reset mid-issue
    dm_cmd_tready = 1'b0;
    accept(mk_cmd(32'h0000_3000, 23'h1000, 4'd9, 1'b0, 1'b0, 6'd0, 1'b0, 4'd0));
    chk("t7_tvalid_pre", 72'(dm_cmd_tvalid), 72'(1));
    usr_rst = 1'b1;
    #1;
    chk("t7_rst_tvalid", 72'(dm_cmd_tvalid), 72'(0));
    chk("t7_rst_busy", 72'(busy), 72'(0));
    chk("t7_rst_ready", 72'(cmd_ready), 72'(0));
    chk("t7_rst_sts_tready", 72'(dm_sts_tready), 72'(0));
    step();
    usr_rst = 1'b0;
    #1;
    chk("t7_rel_ready", 72'(cmd_ready), 72'(1));
    chk("t7_rel_busy", 72'(busy), 72'(0));
    chk("t7_rel_tvalid", 72'(dm_cmd_tvalid), 72'(0));
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
